operand_fetch: RTL

- Read-side initiator for the multi-lane register file. Accepts a bundle of PARALLEL_ORDER source-operand requests with a valid/ready handshake.
- Drives the register file read ports and absorbs its 1-cycle registered read latency.
- Forwards same-cycle and later writes by snooping the register file write lanes, so delivered operands always match architectural state.
- Sits between decode and the execute lanes.

---
 rtl/operand_fetch_if.sv | 45 ++++
 rtl/operand_fetch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// Bundle-level connections between decode, the register file read/write ports,
// and the execute lanes for the operand fetch stage.
interface operand_fetch_if #(
    parameter int PARALLEL_ORDER = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int TAG_WIDTH      = 8
);
    logic                                            in_valid;
    logic                                            in_ready;
    logic [PARALLEL_ORDER-1:0]                       in_src_valid1;
    logic [PARALLEL_ORDER-1:0]                       in_src_valid2;
    logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   in_src_addr1;
    logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   in_src_addr2;
    logic [TAG_WIDTH-1:0]                            in_tag;
    logic [PARALLEL_ORDER-1:0]                       r_valid1;
    logic [PARALLEL_ORDER-1:0]                       r_valid2;
    logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   r_addr1;
    logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   r_addr2;
    logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   r_data1;
    logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   r_data2;
    logic [PARALLEL_ORDER-1:0]                       w_valid;
    logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   w_addr;
    logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   w_data;
    logic                                            out_valid;
    logic                                            out_ready;
    logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   out_op1;
    logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   out_op2;
    logic [TAG_WIDTH-1:0]                            out_tag;

    // The fetch stage is the initiator of register file reads.
    modport master (
        input  in_valid, in_src_valid1, in_src_valid2, in_src_addr1, in_src_addr2, in_tag,
        input  r_data1, r_data2, w_valid, w_addr, w_data, out_ready,
        output in_ready, r_valid1, r_valid2, r_addr1, r_addr2,
        output out_valid, out_op1, out_op2, out_tag
    );

    modport slave (
        output in_valid, in_src_valid1, in_src_valid2, in_src_addr1, in_src_addr2, in_tag,
        output r_data1, r_data2, w_valid, w_addr, w_data, out_ready,
        input  in_ready, r_valid1, r_valid2, r_addr1, r_addr2,
        input  out_valid, out_op1, out_op2, out_tag
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: issues register file reads for a source bundle and delivers
// operands kept coherent with in-flight and later register writes.
module operand_fetch #(
    parameter int PARALLEL_ORDER = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int TAG_WIDTH      = 8
) (
    input logic            clk,
    input logic            rst,
    operand_fetch_if.master bus
);
    localparam int P = PARALLEL_ORDER;
    localparam int A = REG_ADDR_WIDTH;
    localparam int D = REG_DATA_WIDTH;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FRESH = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [TAG_WIDTH-1:0] tag_reg;
    logic                 in_ready;
    logic                 accept;
    logic                 stall;

    // Highest write lane hitting addr wins; returns {hit, data}.
    function automatic logic [D:0] last_write(
        input logic [A-1:0]        addr,
        input logic [P-1:0]        wv,
        input logic [P-1:0][A-1:0] wa,
        input logic [P-1:0][D-1:0] wd
    );
        logic [D:0] r;
        r = '0;
        for (int j = 0; j < P; j++) begin
            if (wv[j] && wa[j] == addr) r = {1'b1, wd[j]};
        end
        return r;
    endfunction

    assign in_ready      = !rst && (state_reg == ST_EMPTY || bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign stall         = (state_reg != ST_EMPTY) && !bus.out_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg != ST_EMPTY);
    assign bus.out_tag   = tag_reg;
    assign bus.r_addr1   = bus.in_src_addr1;
    assign bus.r_addr2   = bus.in_src_addr2;

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_EMPTY || bus.out_ready) state_next = accept ? ST_FRESH : ST_EMPTY;
        else                                        state_next = ST_HELD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            tag_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) tag_reg <= bus.in_tag;
        end
    end

    // One operand slot per (lane gi, source port gj).
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
        for (genvar gj = 0; gj < 2; gj++) begin : g_port
            logic         src_v;
            logic [A-1:0] src_a;
            logic [D-1:0] rd;
            logic         sv_reg, hit_reg;
            logic [A-1:0] sa_reg;
            logic [D-1:0] fd_reg, held_reg;
            logic [D:0]   acc_fwd, snoop_fwd;
            logic [D-1:0] cur_op, snoop_op;

            assign src_v = (gj == 0) ? bus.in_src_valid1[gi] : bus.in_src_valid2[gi];
            assign src_a = (gj == 0) ? bus.in_src_addr1[gi]  : bus.in_src_addr2[gi];
            assign rd    = (gj == 0) ? bus.r_data1[gi]       : bus.r_data2[gi];

            assign acc_fwd   = last_write(src_a,  bus.w_valid, bus.w_addr, bus.w_data);
            assign snoop_fwd = last_write(sa_reg, bus.w_valid, bus.w_addr, bus.w_data);

            always_comb begin
                cur_op = '0;
                if (state_reg == ST_FRESH)     cur_op = !sv_reg ? '0 : (hit_reg ? fd_reg : rd);
                else if (state_reg == ST_HELD) cur_op = held_reg;
            end

            // Writes landing while the bundle waits must show up next cycle.
            assign snoop_op = (sv_reg && snoop_fwd[D]) ? snoop_fwd[D-1:0] : cur_op;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sv_reg   <= 1'b0;
                    sa_reg   <= '0;
                    hit_reg  <= 1'b0;
                    fd_reg   <= '0;
                    held_reg <= '0;
                end else begin
                    if (accept) begin
                        sv_reg  <= src_v;
                        sa_reg  <= src_a;
                        hit_reg <= src_v && acc_fwd[D];
                        fd_reg  <= (src_v && acc_fwd[D]) ? acc_fwd[D-1:0] : '0;
                    end
                    if (stall) held_reg <= snoop_op;
                end
            end

            if (gj == 0) begin : g_p1
                assign bus.r_valid1[gi] = accept && src_v;
                assign bus.out_op1[gi]  = cur_op;
            end else begin : g_p2
                assign bus.r_valid2[gi] = accept && src_v;
                assign bus.out_op2[gi]  = cur_op;
            end
        end
    end
endmodule
